// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - peripheral window base, register offsets and bit indices
package mmio_pkg;

   localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

   localparam logic [27:0] OFF_TH       = 28'h00;
   localparam logic [27:0] OFF_TL       = 28'h04;
   localparam logic [27:0] OFF_TCON     = 28'h08;
   localparam logic [27:0] OFF_LED      = 28'h0C;
   localparam logic [27:0] OFF_DIGI     = 28'h10;
   localparam logic [27:0] OFF_SYSTICK  = 28'h14;
   localparam logic [27:0] OFF_UART_TXD = 28'h18;
   localparam logic [27:0] OFF_UART_RXD = 28'h1C;
   localparam logic [27:0] OFF_UART_CON = 28'h20;

   localparam int TCON_EN     = 0;
   localparam int TCON_IRQ_EN = 1;
   localparam int TCON_IRQ    = 2;

   localparam int CON_TX_BUSY = 0;
   localparam int CON_RX_FULL = 1;
   localparam int CON_OVERRUN = 2;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - reloadable 32-bit timer with sticky interrupt flag
module mmio_timer
   import mmio_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we_th,
   input  logic        we_tl,
   input  logic        we_tcon,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irq
);

   logic at_max;
   logic ovf_set;

   assign at_max  = (tl == 32'hFFFF_FFFF);
   // Overflow only counts when the reload really happens, i.e. no software TL write.
   assign ovf_set = tcon[TCON_EN] && tcon[TCON_IRQ_EN] && at_max && !we_tl;
   assign irq     = tcon[TCON_IRQ];

   always_ff @(posedge clk) begin
      if (!reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (we_th)
            th <= wdata;

         if (we_tl)
            tl <= wdata;
         else if (tcon[TCON_EN])
            tl <= at_max ? th : tl + 32'd1;

         if (we_tcon)
            tcon[1:0] <= wdata[1:0];
         // Write-0-to-clear, with a coincident overflow winning over the clear.
         tcon[TCON_IRQ] <= ovf_set | (we_tcon ? (tcon[TCON_IRQ] & wdata[2]) : tcon[TCON_IRQ]);
      end
   end

endmodule

// File: rtl/mmio_data_mem.sv
// rtl/mmio_data_mem.sv - word RAM with byte enables plus memory-mapped timer/LED/UART block
module mmio_data_mem
   import mmio_pkg::*;
#(
   parameter int RAM_DEPTH  = 256,
   parameter int LED_WIDTH  = 8,
   parameter int DIGI_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [3:0]            byte_en,
   output logic [31:0]           rdata,
   output logic [LED_WIDTH-1:0]  led,
   output logic [DIGI_WIDTH-1:0] digi,
   output logic                  irq,
   output logic [7:0]            uart_tx_data,
   output logic                  uart_tx_valid,
   input  logic                  uart_tx_ready,
   input  logic [7:0]            uart_rx_data,
   input  logic                  uart_rx_valid
);

   localparam int          AW        = $clog2(RAM_DEPTH);
   localparam logic [31:0] RAM_WORDS = RAM_DEPTH;

   logic [31:0]   ram [RAM_DEPTH];
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   logic          periph_hit;
   logic [27:0]   off;
   logic [31:0]   systick;
   logic [7:0]    rxd;
   logic          rx_full;
   logic          overrun;
   logic [31:0]   th;
   logic [31:0]   tl;
   logic [2:0]    tcon;
   logic          wr_periph;
   logic          rd_rxd;
   logic          rd_con;

   assign ram_idx    = addr[AW+1:2];
   assign ram_hit    = (addr[31:28] == 4'h0) && ({2'b00, addr[31:2]} < RAM_WORDS);
   assign periph_hit = (addr[31:28] == PERIPH_BASE[31:28]);
   assign off        = addr[27:0];
   assign wr_periph  = mem_write && periph_hit;
   assign rd_rxd     = mem_read && periph_hit && (off == OFF_UART_RXD);
   assign rd_con     = mem_read && periph_hit && (off == OFF_UART_CON);

   mmio_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .we_th   (wr_periph && (off == OFF_TH)),
      .we_tl   (wr_periph && (off == OFF_TL)),
      .we_tcon (wr_periph && (off == OFF_TCON)),
      .wdata   (wdata),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irq     (irq)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < RAM_DEPTH; i++)
            ram[i] <= '0;
      end else if (mem_write && ram_hit) begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b])
               ram[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         led           <= '0;
         digi          <= '0;
         systick       <= '0;
         uart_tx_data  <= '0;
         uart_tx_valid <= 1'b0;
         rxd           <= '0;
         rx_full       <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         systick <= systick + 32'd1;
         if (wr_periph && (off == OFF_LED))
            led <= wdata[LED_WIDTH-1:0];
         if (wr_periph && (off == OFF_DIGI))
            digi <= wdata[DIGI_WIDTH-1:0];

         // A pending byte is never replaced; the handshake edge takes priority.
         if (uart_tx_valid && uart_tx_ready)
            uart_tx_valid <= 1'b0;
         else if (!uart_tx_valid && wr_periph && (off == OFF_UART_TXD)) begin
            uart_tx_data  <= wdata[7:0];
            uart_tx_valid <= 1'b1;
         end

         if (uart_rx_valid) begin
            rxd     <= uart_rx_data;
            rx_full <= 1'b1;
         end else if (rd_rxd)
            rx_full <= 1'b0;

         if (uart_rx_valid && rx_full && !rd_rxd)
            overrun <= 1'b1;
         else if (rd_con)
            overrun <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (mem_read) begin
         if (ram_hit)
            rdata = ram[ram_idx];
         else if (periph_hit) begin
            case (off)
               OFF_TH:       rdata = th;
               OFF_TL:       rdata = tl;
               OFF_TCON:     rdata = {29'b0, tcon};
               OFF_LED:      rdata = {{(32-LED_WIDTH){1'b0}}, led};
               OFF_DIGI:     rdata = {{(32-DIGI_WIDTH){1'b0}}, digi};
               OFF_SYSTICK:  rdata = systick;
               OFF_UART_TXD: rdata = {24'b0, uart_tx_data};
               OFF_UART_RXD: rdata = {24'b0, rxd};
               OFF_UART_CON: rdata = {29'b0, overrun, rx_full, uart_tx_valid};
               default:      rdata = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mmio_data_mem.sv
// tb/tb_mmio_data_mem.sv - directed self-checking bench for mmio_data_mem
module tb_mmio_data_mem;

   localparam logic [31:0] P = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [3:0]  byte_en = '0;
   logic [31:0] rdata;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irq;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready = 1'b0;
   logic [7:0]  uart_rx_data = '0;
   logic        uart_rx_valid = 1'b0;

   int          total = 0;
   int          bad = 0;
   logic [31:0] cyc = '0;
   logic [31:0] v;

   mmio_data_mem #(.RAM_DEPTH(256), .LED_WIDTH(8), .DIGI_WIDTH(12)) dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr),
      .wdata         (wdata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .byte_en       (byte_en),
      .rdata         (rdata),
      .led           (led),
      .digi          (digi),
      .irq           (irq),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid)
   );

   always #5 clk = ~clk;

   // Reference count of edges since the last reset edge.
   always @(posedge clk) cyc <= reset ? cyc + 32'd1 : 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr = a; wdata = d; byte_en = be; mem_write = 1'b1;
      tick(1);
      mem_write = 1'b0; byte_en = '0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      addr = a; mem_read = 1'b1;
      #1 d = rdata;
      mem_read = 1'b0;
      #1;
   endtask

   task automatic rd_clk(input logic [31:0] a, output logic [31:0] d);
      addr = a; mem_read = 1'b1;
      #1 d = rdata;
      @(posedge clk);
      #1 mem_read = 1'b0;
   endtask

   initial begin
      tick(2);
      chk("rst_led", {24'b0, led}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_txv", {31'b0, uart_tx_valid}, 32'h0);
      peek(P + 32'h14, v); chk("rst_systick", v, 32'h0);
      reset = 1'b1;

      // RAM byte lanes and range
      wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
      wr(32'h10, 32'h0000_5500, 4'b0010);
      peek(32'h10, v); chk("ram_be", v, 32'hDEAD_55EF);
      addr = 32'h10; #1 chk("ram_noread", rdata, 32'h0);
      peek(32'h400, v); chk("ram_oor", v, 32'h0);
      wr(32'h400, 32'h1234_5678, 4'b1111);
      peek(32'h0, v); chk("ram_noalias", v, 32'h0);
      wr(32'h3FC, 32'hCAFE_F00D, 4'b1111);
      peek(32'h3FF, v); chk("ram_last", v, 32'hCAFE_F00D);

      // Timer overflow, reload and interrupt
      wr(P + 32'h00, 32'hFFFF_FFFE, 4'b1111);
      wr(P + 32'h04, 32'hFFFF_FFFD, 4'b1111);
      wr(P + 32'h08, 32'h3, 4'b1111);
      tick(2);
      chk("tmr_irq_pre", {31'b0, irq}, 32'h0);
      peek(P + 32'h04, v); chk("tmr_tl_max", v, 32'hFFFF_FFFF);
      tick(1);
      chk("tmr_irq_set", {31'b0, irq}, 32'h1);
      peek(P + 32'h04, v); chk("tmr_reload", v, 32'hFFFF_FFFE);
      peek(P + 32'h08, v); chk("tmr_tcon", v, 32'h7);
      wr(P + 32'h08, 32'h3, 4'b1111);
      chk("tmr_irq_clr", {31'b0, irq}, 32'h0);
      wr(P + 32'h08, 32'h0, 4'b1111);
      chk("tmr_set_beats_clr", {31'b0, irq}, 32'h1);
      wr(P + 32'h08, 32'h0, 4'b1111);
      chk("tmr_irq_clr2", {31'b0, irq}, 32'h0);
      peek(P + 32'h04, v); chk("tmr_stopped", v, 32'hFFFF_FFFE);

      // UART TX handshake
      wr(P + 32'h18, 32'h41, 4'b0000);
      tick(4);
      chk("tx_valid", {31'b0, uart_tx_valid}, 32'h1);
      peek(P + 32'h20, v); chk("tx_con_busy", v, 32'h1);
      wr(P + 32'h18, 32'h42, 4'b1111);
      chk("tx_hold", {24'b0, uart_tx_data}, 32'h41);
      uart_tx_ready = 1'b1;
      tick(1);
      uart_tx_ready = 1'b0;
      chk("tx_done", {31'b0, uart_tx_valid}, 32'h0);
      chk("tx_data", {24'b0, uart_tx_data}, 32'h41);
      wr(P + 32'h18, 32'h43, 4'b1111);
      uart_tx_ready = 1'b1;
      wr(P + 32'h18, 32'h44, 4'b1111);
      uart_tx_ready = 1'b0;
      chk("tx_coinc_valid", {31'b0, uart_tx_valid}, 32'h0);
      chk("tx_coinc_data", {24'b0, uart_tx_data}, 32'h43);

      // UART RX full/overrun
      uart_rx_data = 8'h5A; uart_rx_valid = 1'b1; tick(1); uart_rx_valid = 1'b0;
      peek(P + 32'h20, v); chk("rx_con_full", v, 32'h2);
      peek(P + 32'h1C, v); chk("rx_data1", v, 32'h5A);
      uart_rx_data = 8'h5B; uart_rx_valid = 1'b1; tick(1); uart_rx_valid = 1'b0;
      peek(P + 32'h20, v); chk("rx_con_ovr", v, 32'h6);
      rd_clk(P + 32'h1C, v); chk("rx_data2", v, 32'h5B);
      peek(P + 32'h20, v); chk("rx_con_after_rxd", v, 32'h4);
      rd_clk(P + 32'h20, v);
      peek(P + 32'h20, v); chk("rx_con_clear", v, 32'h0);
      uart_rx_data = 8'h11; uart_rx_valid = 1'b1; tick(1);
      uart_rx_data = 8'h22;
      rd_clk(P + 32'h1C, v);
      uart_rx_valid = 1'b0;
      peek(P + 32'h20, v); chk("rx_coinc_con", v, 32'h2);
      rd_clk(P + 32'h1C, v); chk("rx_coinc_data", v, 32'h22);

      // LED/DIGI, SYSTICK and unmapped
      wr(P + 32'h0C, 32'h1A5, 4'b1111);
      chk("led_out", {24'b0, led}, 32'hA5);
      peek(P + 32'h0C, v); chk("led_rd", v, 32'hA5);
      wr(P + 32'h10, 32'hFFFF, 4'b0001);
      chk("digi_out", {20'b0, digi}, 32'hFFF);
      wr(P + 32'h14, 32'h0, 4'b1111);
      peek(P + 32'h14, v); chk("systick", v, cyc);
      peek(P + 32'h24, v); chk("unmapped", v, 32'h0);
      peek(32'h2000_0000, v); chk("no_region", v, 32'h0);

      // Mid-operation reset
      wr(P + 32'h08, 32'h1, 4'b1111);
      wr(P + 32'h18, 32'h77, 4'b1111);
      reset = 1'b0; tick(1); reset = 1'b1;
      chk("mrst_led", {24'b0, led}, 32'h0);
      chk("mrst_digi", {20'b0, digi}, 32'h0);
      chk("mrst_tx", {23'b0, uart_tx_valid, uart_tx_data}, 32'h0);
      peek(P + 32'h04, v); chk("mrst_tl", v, 32'h0);
      peek(P + 32'h08, v); chk("mrst_tcon", v, 32'h0);
      peek(P + 32'h14, v); chk("mrst_systick", v, 32'h0);
      peek(32'h10, v); chk("mrst_ram", v, 32'h0);
      tick(1);
      peek(P + 32'h14, v); chk("mrst_systick1", v, 32'h1);
      peek(P + 32'h04, v); chk("mrst_tl_idle", v, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
